ser_out_scheduler: RTL and testbench

Round-robin scheduler that shares the single 64-bit serial output path between NUM_Q queue controllers. Selects one requesting queue, pops one word from it with a one-cycle grant, presents the word to the serial output controller with a one-cycle `valid_data_out` pulse, then holds off until all 64 bits (plus optional idle gap) have shifted out. Sits between the queue controllers and the serial output controller, in the `clk_div_4` domain.

---
 rtl/ser_sched_pkg.sv | 27 ++
 rtl/ser_out_scheduler_rr_arbiter.sv | 40 ++++
 rtl/ser_out_scheduler.sv | 133 +++++++++++++
 tb/tb_ser_out_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_sched_pkg.sv
// ser_sched_pkg: shared types and sizing helpers for the serial output scheduler.
//   state_e      - scheduler FSM states (IDLE, LOAD, SHIFT)
//   DEF_WORD_W   - default word width, equal to the serializer shift register
//   GAP_CYC_MAX  - largest supported idle gap between frames, in bit-times
//   cnt_width()  - SHIFT counter width for a given word width and gap
//   idx_width()  - queue index width for a given queue count
package ser_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int DEF_WORD_W  = 64;
  localparam int GAP_CYC_MAX = 15;

  // The counter never exceeds WORD_W-2+GAP_CYC, so clog2 of the frame period suffices.
  function automatic int cnt_width(input int word_w, input int gap_cyc);
    return $clog2(word_w + gap_cyc);
  endfunction

  function automatic int idx_width(input int num_q);
    return (num_q > 1) ? $clog2(num_q) : 1;
  endfunction

endpackage

// File: rtl/ser_out_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NUM_Q requesters.
//   req_i   [NUM_Q]  request vector
//   ptr_i   [IDX_W]  highest-priority index; priority rises from here with wrap
//   grant_o [NUM_Q]  one-hot winner (all zero when nothing requests)
//   idx_o   [IDX_W]  binary index of the winner (0 when nothing requests)
module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NUM_Q-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan NUM_Q positions starting at the pointer; the first requester wins.
  always_comb begin
    int   pos;
    int   raw;
    logic found;
    logic hit;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    raw     = 0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      raw          = int'(ptr_i) + i;
      pos          = (raw >= NUM_Q) ? (raw - NUM_Q) : raw;
      hit          = !found && req_i[pos];
      grant_o[pos] = grant_o[pos] | hit;
      idx_o        = hit ? IDX_W'(pos) : idx_o;
      found        = found | hit;
    end
  end

endmodule

// File: rtl/ser_out_scheduler.sv
// ser_out_scheduler: shares one WORD_W-bit serial output path among NUM_Q queues.
// Picks a requester round-robin, pops it with a one-cycle grant, hands its word
// to the serializer with a one-cycle valid pulse, then waits out the frame.
//   clk_div_4        sole clock (rising edge)
//   reset            synchronous active-high reset
//   req [NUM_Q]      level requests, bit k = queue k has a head word
//   data_in          head words, queue k at [k*WORD_W +: WORD_W]
//   grant [NUM_Q]    one-hot pop strobe, high only in LOAD
//   data_out         word to serializer, held until the next LOAD
//   valid_data_out   one-cycle serializer load pulse, high only in LOAD
//   busy             high in LOAD and SHIFT
//   cur_q            index of the queue last granted
//   frames_sent      number of words issued, wraps at 16 bits
module ser_out_scheduler
  import ser_sched_pkg::*;
#(
  parameter int NUM_Q   = 4,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int GAP_CYC = 0
) (
  input  logic                      clk_div_4,
  input  logic                      reset,
  input  logic [NUM_Q-1:0]          req,
  input  logic [NUM_Q*WORD_W-1:0]   data_in,
  output logic [NUM_Q-1:0]          grant,
  output logic [WORD_W-1:0]         data_out,
  output logic                      valid_data_out,
  output logic                      busy,
  output logic [$clog2(NUM_Q)-1:0]  cur_q,
  output logic [15:0]               frames_sent
);

  localparam int IDX_W = idx_width(NUM_Q);
  localparam int CNT_W = cnt_width(WORD_W, GAP_CYC);
  // SHIFT lasts WORD_W-1+GAP_CYC cycles, so the next LOAD lands one frame period later.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 2 + GAP_CYC);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_Q-1:0]   grant_q;
  logic [WORD_W-1:0]  data_q;
  logic               valid_q;
  logic               busy_q;
  logic [IDX_W-1:0]   cur_q_q;
  logic [15:0]        frames_q;

  logic [NUM_Q-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [WORD_W-1:0]  arb_word;
  logic               decide;
  logic               issue;

  rr_arbiter #(
    .NUM_Q (NUM_Q),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign arb_word = data_in[int'(arb_idx)*WORD_W +: WORD_W];

  // req is only looked at in a decision cycle: any IDLE cycle or the last SHIFT cycle.
  always_comb begin
    decide = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_CNT));
    issue  = decide && (|req);
  end

  // Scheduler FSM with all outputs registered; LOAD outputs are set on entry.
  always_ff @(posedge clk_div_4) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cur_q_q  <= '0;
      frames_q <= 16'd0;
    end else begin
      grant_q <= '0;
      valid_q <= 1'b0;
      if (issue) begin
        grant_q  <= arb_grant;
        valid_q  <= 1'b1;
        data_q   <= arb_word;
        cur_q_q  <= arb_idx;
        frames_q <= frames_q + 16'd1;
        rr_ptr_q <= (arb_idx == IDX_W'(NUM_Q - 1)) ? '0 : (arb_idx + IDX_W'(1));
      end
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          state_q <= issue ? LOAD : IDLE;
          busy_q  <= issue;
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end
        SHIFT: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            state_q <= issue ? LOAD : IDLE;
            busy_q  <= issue;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant          = grant_q;
  assign data_out       = data_q;
  assign valid_data_out = valid_q;
  assign busy           = busy_q;
  assign cur_q          = cur_q_q;
  assign frames_sent    = frames_q;

endmodule

// File: tb/tb_ser_out_scheduler.sv
// tb_ser_out_scheduler: directed bench for ser_out_scheduler. One instance uses
// the default gap, a second uses GAP_CYC=3; both share clock and reset.
module tb_ser_out_scheduler;

  localparam logic [63:0] D0 = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;

  logic         clk;
  logic         reset;
  logic [3:0]   req0, req3;
  logic [255:0] data_in;
  logic [3:0]   grant0, grant3;
  logic [63:0]  dout0, dout3;
  logic         v0, v3, busy0, busy3;
  logic [1:0]   curq0, curq3;
  logic [15:0]  frames0, frames3;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  logic seen;

  ser_out_scheduler #(.NUM_Q(4), .WORD_W(64), .GAP_CYC(0)) dut0 (
    .clk_div_4(clk), .reset(reset), .req(req0), .data_in(data_in),
    .grant(grant0), .data_out(dout0), .valid_data_out(v0), .busy(busy0),
    .cur_q(curq0), .frames_sent(frames0)
  );

  ser_out_scheduler #(.NUM_Q(4), .WORD_W(64), .GAP_CYC(3)) dut3 (
    .clk_div_4(clk), .reset(reset), .req(req3), .data_in(data_in),
    .grant(grant3), .data_out(dout3), .valid_data_out(v3), .busy(busy3),
    .cur_q(curq3), .frames_sent(frames3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts negedges until the chosen instance shows valid; bounded at 300.
  task automatic wait_pulse(input bit which, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(which ? v3 : v0) && cnt < 300);
  endtask

  initial begin
    reset   = 1'b1;
    req0    = 4'b0000;
    req3    = 4'b0000;
    data_in = {D3, D2, D1, D0};
    cyc(2);
    chk("rst_valid",  {63'd0, v0},   64'd0);
    chk("rst_grant",  {60'd0, grant0}, 64'd0);
    chk("rst_busy",   {63'd0, busy0}, 64'd0);
    chk("rst_cur_q",  {62'd0, curq0}, 64'd0);
    chk("rst_frames", {48'd0, frames0}, 64'd0);
    chk("rst_data",   dout0, 64'd0);
    reset = 1'b0;

    // Idle with no requests
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      seen = seen | v0 | busy0 | (|grant0);
    end
    chk("idle_quiet",  {63'd0, seen}, 64'd0);
    chk("idle_frames", {48'd0, frames0}, 64'd0);

    // Single requester: queue 0
    req0 = 4'b0001;
    wait_pulse(1'b0, n);
    chk("single_lat",   n, 64'd1);
    chk("single_grant", {60'd0, grant0}, 64'h1);
    chk("single_data",  dout0, D0);
    chk("single_busy",  {63'd0, busy0}, 64'd1);
    chk("single_frm1",  {48'd0, frames0}, 64'd1);
    cyc(1);
    chk("single_vlow",  {63'd0, v0}, 64'd0);
    chk("single_glow",  {60'd0, grant0}, 64'd0);
    chk("single_hold",  dout0, D0);
    wait_pulse(1'b0, n);
    chk("single_period", n, 64'd63);
    chk("single_grant2", {60'd0, grant0}, 64'h1);
    chk("single_frm2",  {48'd0, frames0}, 64'd2);
    req0 = 4'b0000;
    cyc(70);
    chk("single_idle",  {63'd0, busy0}, 64'd0);
    chk("single_frmend", {48'd0, frames0}, 64'd2);

    // All requesting from a fresh pointer
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    req0 = 4'b1111;
    wait_pulse(1'b0, n);
    chk("all_lat",   n, 64'd1);
    chk("all_g0",    {60'd0, grant0}, 64'h1);
    chk("all_d0",    dout0, D0);
    wait_pulse(1'b0, n);
    chk("all_p1",    n, 64'd64);
    chk("all_g1",    {60'd0, grant0}, 64'h2);
    chk("all_d1",    dout0, D1);
    chk("all_q1",    {62'd0, curq0}, 64'd1);
    wait_pulse(1'b0, n);
    chk("all_p2",    n, 64'd64);
    chk("all_g2",    {60'd0, grant0}, 64'h4);
    chk("all_d2",    dout0, D2);
    wait_pulse(1'b0, n);
    chk("all_p3",    n, 64'd64);
    chk("all_g3",    {60'd0, grant0}, 64'h8);
    chk("all_d3",    dout0, D3);
    chk("all_q3",    {62'd0, curq0}, 64'd3);
    wait_pulse(1'b0, n);
    chk("all_p4",    n, 64'd64);
    chk("all_g4",    {60'd0, grant0}, 64'h1);
    chk("all_frm5",  {48'd0, frames0}, 64'd5);
    req0 = 4'b0000;
    cyc(70);

    // Late request rises mid-SHIFT and waits for the decision cycle
    req0 = 4'b0001;
    wait_pulse(1'b0, n);
    chk("late_g0",  {60'd0, grant0}, 64'h1);
    req0 = 4'b0000;
    cyc(10);
    req0 = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen = seen | v0 | (|grant0);
    end
    chk("late_nogrant", {63'd0, seen}, 64'd0);
    wait_pulse(1'b0, n);
    chk("late_when",  n, 64'd34);
    chk("late_g2",    {60'd0, grant0}, 64'h4);
    chk("late_q2",    {62'd0, curq0}, 64'd2);
    chk("late_frm",   {48'd0, frames0}, 64'd7);
    // A request pulse that drops before the decision is never served
    req0 = 4'b0000;
    cyc(20);
    req0 = 4'b1000;
    cyc(1);
    req0 = 4'b0000;
    cyc(60);
    chk("drop_busy", {63'd0, busy0}, 64'd0);
    chk("drop_frm",  {48'd0, frames0}, 64'd7);

    // Reset in the middle of SHIFT
    req0 = 4'b0001;
    wait_pulse(1'b0, n);
    chk("mid_g0",   {60'd0, grant0}, 64'h1);
    chk("mid_frm",  {48'd0, frames0}, 64'd8);
    req0 = 4'b0000;
    cyc(20);
    reset = 1'b1;
    cyc(1);
    chk("mid_busy",  {63'd0, busy0}, 64'd0);
    chk("mid_valid", {63'd0, v0}, 64'd0);
    chk("mid_grant", {60'd0, grant0}, 64'd0);
    chk("mid_frm0",  {48'd0, frames0}, 64'd0);
    chk("mid_curq",  {62'd0, curq0}, 64'd0);
    reset = 1'b0;
    // 1001 exposes the pointer: a cleared pointer picks queue 0, a stale one queue 3
    req0 = 4'b1001;
    wait_pulse(1'b0, n);
    chk("post_lat",  n, 64'd1);
    chk("post_g0",   {60'd0, grant0}, 64'h1);
    chk("post_frm",  {48'd0, frames0}, 64'd1);
    req0 = 4'b1000;
    wait_pulse(1'b0, n);
    chk("post_p",    n, 64'd64);
    chk("post_g3",   {60'd0, grant0}, 64'h8);
    chk("post_q3",   {62'd0, curq0}, 64'd3);
    chk("post_d3",   dout0, D3);
    // Reset during LOAD: outputs clear on the following edge
    reset = 1'b1;
    req0  = 4'b0000;
    cyc(1);
    chk("ldrst_valid", {63'd0, v0}, 64'd0);
    chk("ldrst_grant", {60'd0, grant0}, 64'd0);
    chk("ldrst_frm",   {48'd0, frames0}, 64'd0);
    chk("ldrst_busy",  {63'd0, busy0}, 64'd0);
    reset = 1'b0;

    // Idle gap of 3 bit-times stretches the period to 67
    req3 = 4'b0010;
    wait_pulse(1'b1, n);
    chk("gap_lat",   n, 64'd1);
    chk("gap_g1",    {60'd0, grant3}, 64'h2);
    chk("gap_d1",    dout3, D1);
    wait_pulse(1'b1, n);
    chk("gap_p1",    n, 64'd67);
    wait_pulse(1'b1, n);
    chk("gap_p2",    n, 64'd67);
    chk("gap_frm",   {48'd0, frames3}, 64'd3);
    req3 = 4'b0000;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
